clock_display_ctrl: RTL
=======================

// Module: clock_display_ctrl
// PURPOSE
//  Parametrised HH-MM-SS real-time clock with an 8-digit multiplexed 7-segment driver.
//  Adds a time-set mode (hour/minute adjust with field blink), 12/24-hour display and
//  selectable segment polarity. Sits between board pushbuttons (debounced upstream) and
//  the seg/sel pins of the display board.
// PARAMETERS
//  CLK_HZ       50_000_000  clk cycles per second; prescaler terminal count is CLK_HZ-1
//  SCAN_DIV     50_000      clk cycles each digit stays selected (>=1)
//  SEG_ACT_LOW  0           1: seg output bitwise inverted (common-anode boards)
// PORTS
//  clk      in   1  system clock
//  rst      in   1  synchronous, active-high reset
//  mode_btn in   1  mode advance, acted on at its rising edge (clean, clk-synchronous)
//  inc_btn  in   1  increment selected field, acted on at its rising edge
//  fmt12    in   1  1: 12-hour display, 0: 24-hour display (display only, no effect on count)
//  seg      out  8  segments {dp,g,f,e,d,c,b,a}, active high unless SEG_ACT_LOW
//  sel      out  3  digit index 0..7, digit 0 = leftmost
//  hh_o     out  5  hours, binary 0..23
//  mm_o     out  6  minutes, binary 0..59
//  ss_o     out  6  seconds, binary 0..59
//  mode_o   out  2  00 RUN, 01 SET_H, 10 SET_M
// BEHAVIOUR
//  Reset: hh=mm=ss=0, mode RUN, prescaler=0, scan counter=0, sel=0, seg=blank (8'h00, 8'hFF if act-low).
//  Edge detect: one registered copy per button; event = in & ~prev. Held level = one event.
//  Prescaler: counts 0..CLK_HZ-1 in all modes; sec_tick = 1 cycle when cnt==CLK_HZ-1, then wraps to 0.
//  FSM: RUN -mode-> SET_H -mode-> SET_M -mode-> RUN. mode and inc in same cycle: mode wins, inc dropped.
//  RUN: on sec_tick ss++; ss 59->0 carries mm++; mm 59->0 carries hh++; hh 23->0. All carries same cycle.
//   inc ignored in RUN.
//  SET_H: count frozen; inc: hh = (hh==23) ? 0 : hh+1. No effect on mm/ss.
//  SET_M: count frozen; inc: mm = (mm==59) ? 0 : mm+1, no carry into hh.
//  SET_M->RUN transition: ss=0 and prescaler=0 in that cycle; first sec_tick CLK_HZ cycles later.
//  rst in any mode overrides all events and returns to RUN with reset values.
//  Scan: scan counter 0..SCAN_DIV-1; at terminal count digit index d = d+1 (7 wraps to 0).
//   sel and seg are registered together: both reflect d and the current time one cycle after change.
//  Digit map: 0,1 = hour tens/units; 2 = dash; 3,4 = minutes; 5 = dash; 6,7 = seconds.
//  Codes: 0..9 = 3f 06 5b 4f 66 6d 7d 07 7f 6f; dash = 40; blank = 00. Leading zeros shown.
//  fmt12=1: shown hour = (hh%12==0) ? 12 : hh%12; digit 7 dp (bit7) lit when hh>=12 (PM).
//  fmt12=0: hour shown 00..23, dp never lit.
//  Blink: SET_H blanks digits 0,1 and SET_M blanks digits 3,4 while prescaler cnt >= CLK_HZ/2.
//  SEG_ACT_LOW=1: final seg = ~pattern (incl. blank and dp).
//  Outputs hh_o/mm_o/ss_o/mode_o are direct register values (no extra latency).
// TESTING  (CLK_HZ=10, SCAN_DIV=2, SEG_ACT_LOW=0 unless noted)
//  1 Set 23:59 via SET mode, return to RUN, run 600 clks -> ss 59 then 00:00:00 on same tick.
//  2 Time 12:34:56, fmt12=0 -> sel 0..7 each held 2 clks, seg 06 5b 40 4f 66 40 6d 7d.
//  3 mode, 3 inc -> hh=3; mode, 65 inc -> mm=5, hh=3; mode -> RUN, ss=0, ss=1 exactly 10 clks later.
//  4 fmt12=1: hh=0 -> digits 0,1 = 06 5b, no dp; hh=13 -> 3f 06, digit 7 seg bit7=1.
//  5 mode+inc same cycle -> mode_o advances, field unchanged; inc in RUN -> no change;
//    rst during SET_M -> mode_o=00, 00:00:00, seg=00.
//  6 SEG_ACT_LOW=1: reset seg=FF; digit '0' shows C0; SET_H blink digits show FF for cnt 5..9.

Source files
------------

// File: rtl/clock_display_ctrl.sv
// rtl/clock_display_ctrl.sv - HH-MM-SS clock with set mode, 12/24h display and 8-digit 7-segment scan
module clock_display_ctrl #(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned SCAN_DIV    = 50_000,
  parameter bit          SEG_ACT_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_btn,
  input  logic       inc_btn,
  input  logic       fmt12,
  output logic [7:0] seg,
  output logic [2:0] sel,
  output logic [4:0] hh_o,
  output logic [5:0] mm_o,
  output logic [5:0] ss_o,
  output logic [1:0] mode_o
);

  localparam int unsigned PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_TC   = PW'(CLK_HZ - 1);
  localparam logic [PW-1:0] BLINK_TH = PW'(CLK_HZ / 2);
  localparam logic [SW-1:0] SCAN_TC  = SW'(SCAN_DIV - 1);
  localparam logic [7:0]    SEG_BLANK = SEG_ACT_LOW ? 8'hFF : 8'h00;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    SET_H = 2'b01,
    SET_M = 2'b10
  } mode_e;

  mode_e         mode_q;
  logic          mode_prev_q, inc_prev_q;
  logic [PW-1:0] pre_q;
  logic [4:0]    hh_q;
  logic [5:0]    mm_q, ss_q;
  logic [SW-1:0] scan_q;
  logic [2:0]    dig_q, sel_q;
  logic [7:0]    seg_q, seg_d;

  logic mode_ev, inc_ev, sec_tick;

  // Mode press wins over a simultaneous increment press.
  assign mode_ev  = mode_btn & ~mode_prev_q;
  assign inc_ev   = inc_btn & ~inc_prev_q & ~mode_ev;
  assign sec_tick = (pre_q == PRE_TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      pre_q       <= '0;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
    end else begin
      mode_prev_q <= mode_btn;
      inc_prev_q  <= inc_btn;
      pre_q       <= sec_tick ? '0 : pre_q + 1'b1;
      case (mode_q)
        RUN: begin
          if (sec_tick) begin
            if (ss_q == 6'd59) begin
              ss_q <= '0;
              if (mm_q == 6'd59) begin
                mm_q <= '0;
                hh_q <= (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
              end else begin
                mm_q <= mm_q + 6'd1;
              end
            end else begin
              ss_q <= ss_q + 6'd1;
            end
          end
          if (mode_ev) mode_q <= SET_H;
        end
        SET_H: begin
          if (mode_ev) mode_q <= SET_M;
          else if (inc_ev) hh_q <= (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end
        SET_M: begin
          // Leaving set mode restarts the second so the first tick is a full second away.
          if (mode_ev) begin
            mode_q <= RUN;
            ss_q   <= '0;
            pre_q  <= '0;
          end else if (inc_ev) begin
            mm_q <= (mm_q == 6'd59) ? 6'd0 : mm_q + 6'd1;
          end
        end
        default: mode_q <= RUN;
      endcase
    end
  end

  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'd0:    seg7 = 8'h3f;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5b;
      4'd3:    seg7 = 8'h4f;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6d;
      4'd6:    seg7 = 8'h7d;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7f;
      4'd9:    seg7 = 8'h6f;
      default: seg7 = 8'h00;
    endcase
  endfunction

  logic [4:0] h_mod12, hour_disp;
  logic [3:0] nib;
  logic [7:0] pat;
  logic       blink_off;

  always_comb begin
    h_mod12   = (hh_q >= 5'd12) ? hh_q - 5'd12 : hh_q;
    hour_disp = fmt12 ? ((h_mod12 == 5'd0) ? 5'd12 : h_mod12) : hh_q;
    nib       = '0;
    case (dig_q)
      3'd0:    nib = 4'(hour_disp / 5'd10);
      3'd1:    nib = 4'(hour_disp % 5'd10);
      3'd3:    nib = 4'(mm_q / 6'd10);
      3'd4:    nib = 4'(mm_q % 6'd10);
      3'd6:    nib = 4'(ss_q / 6'd10);
      3'd7:    nib = 4'(ss_q % 6'd10);
      default: nib = '0;
    endcase
    pat = ((dig_q == 3'd2) || (dig_q == 3'd5)) ? 8'h40 : seg7(nib);
    if ((dig_q == 3'd7) && fmt12 && (hh_q >= 5'd12)) pat[7] = 1'b1;
    // Field being set is dark during the second half of each second.
    blink_off = (pre_q >= BLINK_TH) &&
                (((mode_q == SET_H) && (dig_q <= 3'd1)) ||
                 ((mode_q == SET_M) && ((dig_q == 3'd3) || (dig_q == 3'd4))));
    if (blink_off) pat = 8'h00;
    seg_d = SEG_ACT_LOW ? ~pat : pat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= '0;
      dig_q  <= '0;
      sel_q  <= '0;
      seg_q  <= SEG_BLANK;
    end else begin
      if (scan_q == SCAN_TC) begin
        scan_q <= '0;
        dig_q  <= dig_q + 3'd1;
      end else begin
        scan_q <= scan_q + 1'b1;
      end
      sel_q <= dig_q;
      seg_q <= seg_d;
    end
  end

  assign seg    = seg_q;
  assign sel    = sel_q;
  assign hh_o   = hh_q;
  assign mm_o   = mm_q;
  assign ss_o   = ss_q;
  assign mode_o = mode_q;

endmodule
